// File: rtl/action_input_decoder_pkg.sv
// Shared action codes, FSM encoding and small decode helpers for the care-button front end.
package action_input_decoder_pkg;

    localparam int N_ACTIONS = 6;

    localparam logic [2:0] ACT_NONE   = 3'd0;
    localparam logic [2:0] ACT_FEED   = 3'd1;
    localparam logic [2:0] ACT_PLAY   = 3'd2;
    localparam logic [2:0] ACT_HEAL   = 3'd3;
    localparam logic [2:0] ACT_CLEAN  = 3'd4;
    localparam logic [2:0] ACT_SLEEP  = 3'd5;
    localparam logic [2:0] ACT_SOCIAL = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_COOL  = 2'd2
    } state_e;

    // Lowest set request index wins, so feed has the highest priority.
    function automatic logic [2:0] prio_code(input logic [N_ACTIONS-1:0] req);
        logic [2:0] code;
        code = ACT_NONE;
        for (int i = N_ACTIONS - 1; i >= 0; i--) begin
            if (req[i]) begin
                code = 3'(i + 1);
            end
        end
        return code;
    endfunction

    function automatic logic [N_ACTIONS-1:0] code_onehot(input logic [2:0] code);
        logic [N_ACTIONS-1:0] oh;
        oh = {N_ACTIONS{1'b0}};
        for (int i = 0; i < N_ACTIONS; i++) begin
            if (code == 3'(i + 1)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/action_input_decoder_debounce.sv
// One button: two-flop synchroniser, stability counter, debounced level and a rise strobe.
module button_debounce #(
    parameter logic [15:0] DEBOUNCE_COUNT = 16'd50_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    logic        sync1_q;
    logic        sync2_q;
    logic        level_q;
    logic        level_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Count cycles of disagreement; flip the level on the cycle the count would reach its terminal value.
    always_comb begin
        level_d = level_q;
        cnt_d   = 16'd0;
        if (sync2_q != level_q) begin
            if ((DEBOUNCE_COUNT == 16'd0) || (cnt_q >= DEBOUNCE_COUNT - 16'd1)) begin
                level_d = sync2_q;
                cnt_d   = 16'd0;
            end else begin
                cnt_d   = cnt_q + 16'd1;
            end
        end else begin
            cnt_d = 16'd0;
        end
    end

    // Synchroniser, counter and debounced level state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobe coincides with the edge that raises the level, so the pending bit lands together with it.
    assign rise_o = level_d & ~level_q;

endmodule

// File: rtl/action_input_decoder.sv
// Care-button front end: debounce six buttons, latch presses, and offer one action at a time with cooldown.
module action_input_decoder
    import action_input_decoder_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_COUNT = 16'd50_000,
    parameter logic [23:0] COOLDOWN_COUNT = 24'd10_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_ACTIONS-1:0] buttons,
    output logic                 action_valid,
    output logic [2:0]           action_code,
    input  logic                 action_ready,
    output logic                 busy,
    output logic [N_ACTIONS-1:0] pending
);

    logic [N_ACTIONS-1:0] rise_s;
    logic [N_ACTIONS-1:0] clr_s;
    logic [N_ACTIONS-1:0] pending_q;
    logic [N_ACTIONS-1:0] pending_d;
    state_e               state_q;
    logic                 action_valid_q;
    logic [2:0]           action_code_q;
    logic                 busy_q;
    logic [23:0]          cool_cnt_q;

    for (genvar g = 0; g < N_ACTIONS; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .btn_i  (buttons[g]),
            .rise_o (rise_s[g])
        );
    end

    // A fresh press on the accepting edge outranks the clear, so OR the rises in last.
    always_comb begin
        clr_s = {N_ACTIONS{1'b0}};
        if ((state_q == ST_OFFER) && action_ready) begin
            clr_s = code_onehot(action_code_q);
        end else begin
            clr_s = {N_ACTIONS{1'b0}};
        end
        pending_d = (pending_q & ~clr_s) | rise_s;
    end

    // Pending request register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= {N_ACTIONS{1'b0}};
        end else begin
            pending_q <= pending_d;
        end
    end

    // Offer/cooldown sequencer with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            action_valid_q <= 1'b0;
            action_code_q  <= ACT_NONE;
            busy_q         <= 1'b0;
            cool_cnt_q     <= 24'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pending_q != {N_ACTIONS{1'b0}}) begin
                        state_q        <= ST_OFFER;
                        action_valid_q <= 1'b1;
                        action_code_q  <= prio_code(pending_q);
                    end
                end
                ST_OFFER: begin
                    if (action_ready) begin
                        action_valid_q <= 1'b0;
                        action_code_q  <= ACT_NONE;
                        cool_cnt_q     <= 24'd0;
                        if (COOLDOWN_COUNT == 24'd0) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_COOL;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_COOL: begin
                    if (cool_cnt_q >= COOLDOWN_COUNT - 24'd1) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        cool_cnt_q <= 24'd0;
                    end else begin
                        cool_cnt_q <= cool_cnt_q + 24'd1;
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    action_valid_q <= 1'b0;
                    action_code_q  <= ACT_NONE;
                    busy_q         <= 1'b0;
                    cool_cnt_q     <= 24'd0;
                end
            endcase
        end
    end

    assign action_valid = action_valid_q;
    assign action_code  = action_code_q;
    assign busy         = busy_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_action_input_decoder.sv
// Directed bench: expected handshakes go to a scoreboard queue, a negedge monitor pops and compares them.
module tb_action_input_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] buttons;
    logic       action_valid;
    logic [2:0] action_code;
    logic       action_ready;
    logic       busy;
    logic [5:0] pending;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int code;
        int cyc;
    } exp_t;

    exp_t sb_q[$];

    action_input_decoder #(
        .DEBOUNCE_COUNT(16'd4),
        .COOLDOWN_COUNT(24'd8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .buttons      (buttons),
        .action_valid (action_valid),
        .action_code  (action_code),
        .action_ready (action_ready),
        .busy         (busy),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic go_to(input int t);
        while (cyc < t) nxt();
    endtask

    task automatic push(input int code, input int c);
        exp_t e;
        e.code = code;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    // Monitor: every handshake seen before the next edge must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && action_valid && action_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_action: got code %0d at cycle %0d, expected no action", action_code, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_code", 32'(action_code), e.code);
                    check("sb_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, %0d checks so far", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int k2;
        int w;
        reset        = 1'b1;
        buttons      = 6'h00;
        action_ready = 1'b0;
        repeat (3) nxt();
        check("rst_valid", 32'(action_valid), 0);
        check("rst_code", 32'(action_code), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pending", 32'(pending), 0);
        reset = 1'b0;
        repeat (2) nxt();

        // 1: held play button, ready tied high
        k = cyc;
        action_ready = 1'b1;
        buttons[1]   = 1'b1;
        push(2, k + 7);
        go_to(k + 6);
        check("t1_valid_early", 32'(action_valid), 0);
        go_to(k + 7);
        check("t1_valid", 32'(action_valid), 1);
        check("t1_code", 32'(action_code), 2);
        go_to(k + 8);
        check("t1_busy_start", 32'(busy), 1);
        check("t1_valid_drop", 32'(action_valid), 0);
        check("t1_code_drop", 32'(action_code), 0);
        go_to(k + 15);
        check("t1_busy_end", 32'(busy), 1);
        go_to(k + 16);
        check("t1_busy_fall", 32'(busy), 0);
        buttons[1] = 1'b0;
        go_to(k + 30);

        // 2: 3-cycle glitch is rejected, 4-cycle pulse is accepted
        k = cyc;
        buttons[0] = 1'b1;
        go_to(k + 3);
        buttons[0] = 1'b0;
        go_to(k + 12);
        check("t2_glitch_pending", 32'(pending), 0);
        check("t2_glitch_valid", 32'(action_valid), 0);
        k2 = cyc;
        buttons[0] = 1'b1;
        push(1, k2 + 7);
        go_to(k2 + 4);
        buttons[0] = 1'b0;
        go_to(k2 + 7);
        check("t2_pulse_valid", 32'(action_valid), 1);
        go_to(k2 + 25);

        // 3: simultaneous clean+feed, served in priority order
        k = cyc;
        buttons = 6'h09;
        push(1, k + 7);
        push(4, k + 17);
        go_to(k + 6);
        check("t3_pending_both", 32'(pending), 32'h09);
        go_to(k + 8);
        check("t3_pending_clean", 32'(pending), 32'h08);
        go_to(k + 10);
        buttons = 6'h00;
        go_to(k + 18);
        check("t3_pending_empty", 32'(pending), 0);
        go_to(k + 30);

        // 4: code held stable under backpressure while a higher-priority press arrives
        k = cyc;
        action_ready = 1'b0;
        buttons[2]   = 1'b1;
        push(3, k + 27);
        push(1, k + 37);
        go_to(k + 7);
        check("t4_code", 32'(action_code), 3);
        go_to(k + 8);
        buttons[0] = 1'b1;
        go_to(k + 20);
        check("t4_hold_valid", 32'(action_valid), 1);
        check("t4_hold_code", 32'(action_code), 3);
        check("t4_pending", 32'(pending), 32'h05);
        go_to(k + 27);
        action_ready = 1'b1;
        go_to(k + 28);
        check("t4_busy", 32'(busy), 1);
        check("t4_pending_after", 32'(pending), 32'h01);
        go_to(k + 37);
        check("t4_next_code", 32'(action_code), 1);
        buttons = 6'h00;
        go_to(k + 50);

        // 5: press during cooldown is latched and served one cycle after busy falls
        k = cyc;
        buttons[4] = 1'b1;
        push(5, k + 7);
        push(6, k + 17);
        go_to(k + 8);
        buttons[4] = 1'b0;
        buttons[5] = 1'b1;
        go_to(k + 14);
        check("t5_pending_cool", 32'(pending), 32'h20);
        check("t5_busy", 32'(busy), 1);
        go_to(k + 16);
        check("t5_busy_fall", 32'(busy), 0);
        check("t5_valid_gap", 32'(action_valid), 0);
        go_to(k + 17);
        check("t5_code", 32'(action_code), 6);
        buttons = 6'h00;
        go_to(k + 30);

        // 7: re-press lands on the accepting edge of the same button, set wins
        k = cyc;
        action_ready = 1'b0;
        buttons[3]   = 1'b1;
        push(4, k + 20);
        push(4, k + 30);
        go_to(k + 7);
        buttons[3] = 1'b0;
        go_to(k + 15);
        buttons[3] = 1'b1;
        go_to(k + 20);
        action_ready = 1'b1;
        go_to(k + 21);
        check("t7_set_wins", 32'(pending), 32'h08);
        check("t7_busy", 32'(busy), 1);
        go_to(k + 22);
        buttons[3] = 1'b0;
        go_to(k + 31);
        check("t7_pending_clear", 32'(pending), 0);
        go_to(k + 45);

        // 6a: reset during OFFER
        k = cyc;
        action_ready = 1'b0;
        buttons[1]   = 1'b1;
        go_to(k + 8);
        check("t6_offer_valid", 32'(action_valid), 1);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(action_valid), 0);
        check("t6_rst_code", 32'(action_code), 0);
        check("t6_rst_pending", 32'(pending), 0);
        buttons = 6'h00;
        repeat (3) nxt();
        reset = 1'b0;
        action_ready = 1'b1;
        k2 = cyc;
        go_to(k2 + 20);
        check("t6_quiet_valid", 32'(action_valid), 0);
        check("t6_quiet_pending", 32'(pending), 0);

        // 6b: reset during COOLDOWN, then a fresh press works
        k = cyc;
        buttons[2] = 1'b1;
        push(3, k + 7);
        go_to(k + 10);
        check("t6_cool_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("t6_rst_busy", 32'(busy), 0);
        buttons = 6'h00;
        repeat (3) nxt();
        reset = 1'b0;
        k2 = cyc;
        go_to(k2 + 20);
        check("t6_quiet_busy", 32'(busy), 0);
        k = cyc;
        buttons[0] = 1'b1;
        push(1, k + 7);
        go_to(k + 8);
        buttons = 6'h00;
        go_to(k + 20);

        w = 0;
        while ((sb_q.size() != 0) && (w < 50)) begin
            nxt();
            w++;
        end
        check("sb_drained", 32'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
